// File: rtl/fib_stream_checker.sv
// Checks a Fibonacci term stream (mod 2^WIDTH) against its seeds and the running recurrence.
// Reports the first mismatch, the first wrapped sum and a saturating count of accepted terms.
module fib_stream_checker #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 16,
  parameter int SEED0 = 0,
  parameter int SEED1 = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             seq_ok,
  output logic             err,
  output logic [CNT_W-1:0] err_index,
  output logic [WIDTH-1:0] err_expected,
  output logic [WIDTH-1:0] err_actual,
  output logic             overflow,
  output logic [CNT_W-1:0] ovf_index,
  output logic [CNT_W-1:0] term_count
);

  localparam logic [1:0] S_SEED0 = 2'd0;
  localparam logic [1:0] S_SEED1 = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam logic [WIDTH-1:0] L_SEED0 = WIDTH'(SEED0);
  localparam logic [WIDTH-1:0] L_SEED1 = WIDTH'(SEED1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_prev1;
  logic [WIDTH-1:0] r_prev2;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_err_index;
  logic [WIDTH-1:0] r_err_expected;
  logic [WIDTH-1:0] r_err_actual;
  logic             r_overflow;
  logic [CNT_W-1:0] r_ovf_index;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_expected;
  logic             w_match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Carry bit of the sum flags a wrap; the low bits are the modular expectation.
  assign w_sum = {1'b0, r_prev1} + {1'b0, r_prev2};

  always_comb begin
    w_expected = w_sum[WIDTH-1:0];
    case (r_state)
      S_SEED0: w_expected = L_SEED0;
      S_SEED1: w_expected = L_SEED1;
      default: w_expected = w_sum[WIDTH-1:0];
    endcase
  end

  assign w_match = (in_data == w_expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_SEED0;
      r_prev1        <= '0;
      r_prev2        <= '0;
      r_cnt          <= '0;
      r_err_index    <= '0;
      r_err_expected <= '0;
      r_err_actual   <= '0;
      r_overflow     <= 1'b0;
      r_ovf_index    <= '0;
    end else if (clear) begin
      r_state        <= S_SEED0;
      r_prev1        <= '0;
      r_prev2        <= '0;
      r_cnt          <= '0;
      r_err_index    <= '0;
      r_err_expected <= '0;
      r_err_actual   <= '0;
      r_overflow     <= 1'b0;
      r_ovf_index    <= '0;
    end else if (in_valid) begin
      r_cnt <= sat_inc(r_cnt);
      if (r_state != S_ERROR) begin
        if (!w_match) begin
          r_state        <= S_ERROR;
          r_err_index    <= r_cnt;
          r_err_expected <= w_expected;
          r_err_actual   <= in_data;
        end else begin
          case (r_state)
            S_SEED0: begin
              r_state <= S_SEED1;
              r_prev2 <= in_data;
            end
            S_SEED1: begin
              r_state <= S_CHECK;
              r_prev1 <= in_data;
            end
            default: begin
              r_prev2 <= r_prev1;
              r_prev1 <= in_data;
            end
          endcase
        end
        // Wrap detection applies to the checked term whether or not it matched.
        if (r_state == S_CHECK && w_sum[WIDTH] && !r_overflow) begin
          r_overflow  <= 1'b1;
          r_ovf_index <= r_cnt;
        end
      end
    end
  end

  assign seq_ok       = (r_state == S_CHECK);
  assign err          = (r_state == S_ERROR);
  assign err_index    = r_err_index;
  assign err_expected = r_err_expected;
  assign err_actual   = r_err_actual;
  assign overflow     = r_overflow;
  assign ovf_index    = r_ovf_index;
  assign term_count   = r_cnt;

endmodule

// File: doc/fib_stream_checker.md
Name: fib_stream_checker

Overview:
- Downstream consumer of the Fibonacci generator output stream.
- Samples each valid term and checks that it equals the sum of the two previous terms, modulo 2^WIDTH. The first two terms are checked against parameterised seeds.
- Reports sticky error and first-mismatch details, a sticky wrap-around (overflow) flag with its index, and a running term count.
- Sits between the generator and the bench/scoreboard, or feeds an on-chip status register.

Parameters:
- WIDTH, 10, data width of the checked terms; must match the generator.
- CNT_W, 16, width of the term counter and index outputs.
- SEED0, 0, required value of term 0.
- SEED1, 1, required value of term 1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a term this cycle.
- in_data  input  WIDTH  term from the generator.
- clear  input  1  synchronous restart of checking; same effect as rst, but takes effect on the clock edge.
- seq_ok  output  1  high while in CHECK state: both seeds matched and no mismatch so far.
- err  output  1  sticky mismatch flag.
- err_index  output  CNT_W  index of the first mismatching term.
- err_expected  output  WIDTH  expected value at the first mismatch.
- err_actual  output  WIDTH  received value at the first mismatch.
- overflow  output  1  sticky flag: an expected sum carried out of WIDTH bits.
- ovf_index  output  CNT_W  index of the first term whose expected sum wrapped.
- term_count  output  CNT_W  number of terms accepted; saturates at 2^CNT_W-1.

Behaviour:
- Reset (rst high, asynchronous): state=S_SEED0; all outputs 0; internal prev1/prev2 registers 0.
- States: S_SEED0, S_SEED1, S_CHECK, S_ERROR. The state advances only on a cycle with in_valid=1. Idle cycles (in_valid=0) change nothing.
- S_SEED0, sample accepted:
  - in_data==SEED0: go to S_SEED1, prev2<=in_data.
  - Otherwise: go to S_ERROR, capture err_index=0, err_expected=SEED0, err_actual=in_data.
- S_SEED1, sample accepted:
  - in_data==SEED1: go to S_CHECK, prev1<=in_data.
  - Otherwise: go to S_ERROR, capture index 1, expected SEED1.
- S_CHECK, sample accepted:
  - Compute sum = prev1 + prev2 in WIDTH+1 bits; expected = sum[WIDTH-1:0].
  - Match: prev2<=prev1, prev1<=in_data, stay in S_CHECK.
  - Mismatch: go to S_ERROR, capture term_count as err_index, plus expected and actual.
  - sum[WIDTH]=1 and overflow==0: set overflow, ovf_index<=term_count. This is evaluated in the same cycle as the match check, whether or not the term matches.
  - Wrapped terms are still checked modulo 2^WIDTH; a wrap is not an error.
- S_ERROR:
  - Terminal until rst or clear.
  - No further comparisons; err and the captured fields hold.
  - term_count keeps counting accepted samples (saturating).
- term_count increments by 1 on every accepted sample in every state; it holds at all-ones.
- Latency: every output reflects a sample one cycle after the edge at which it was accepted (registered outputs, no combinational path from in_data).
- err is asserted registered together with the transition to S_ERROR; seq_ok drops in the same cycle.
- clear=1 at a clock edge: identical to reset. Any in_valid in that cycle is dropped (clear has priority).
- rst asserted mid-stream: immediate return to reset values. Checking restarts at term 0 with the first sample after rst deasserts.
- Indices saturate with term_count. If term_count has saturated, err_index/ovf_index report the saturated value.

Test Plan:
- WIDTH=10, stream 0,1,1,2,3,5,8,13 with in_valid every cycle -> seq_ok=1 from the cycle after term 1; err=0; term_count=8.
- Correct stream continued to term 20 (…,610,987,573,536,85) -> overflow=1, ovf_index=17 one cycle after term 573; err stays 0; seq_ok stays 1.
- Stream 0,1,1,2,4 -> err=1 one cycle after "4"; err_index=4, err_expected=3, err_actual=4; seq_ok=0. Further samples 0,0 keep the error fields unchanged; term_count=7.
- First sample 5 -> err=1, err_index=0, err_expected=0, err_actual=5. First samples 0,7 -> err_index=1, err_expected=1, err_actual=7.
- Correct stream with random in_valid gaps (0–3 idle cycles) -> identical results to the gapless run; term_count counts only valid cycles.
- rst pulse mid-stream after term 6: all outputs 0 immediately, no clock needed. Then clear asserted together with in_valid (sample dropped) -> restart from 0,1,… passes with term_count counting from 0. CNT_W=3 with 10 correct terms -> term_count saturates at 7.
